// File: rtl/paramest_nn_mac_accum_if.sv
// Term/result stream bundle for the neuron MAC accumulator.
// The slave modport is the accumulator; the master modport is its environment.
`default_nettype none

interface paramest_nn_mac_accum_if #(
  parameter int PROD_WIDTH = 28,
  parameter int OUT_WIDTH  = 16
);
  logic signed [PROD_WIDTH-1:0] prod_in;
  logic signed [PROD_WIDTH-1:0] bias_in;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [OUT_WIDTH-1:0]  res_out;
  logic                         res_sat;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output prod_in, bias_in, in_valid, out_ready,
    input  in_ready, res_out, res_sat, out_valid
  );

  modport slave (
    input  prod_in, bias_in, in_valid, out_ready,
    output in_ready, res_out, res_sat, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/paramest_nn_mac_accum.sv
// Sums N_TERMS signed products plus a bias, then rounds, shifts, optionally ReLUs
// and saturates into one registered neuron result held until downstream accepts it.
`default_nettype none

module paramest_nn_mac_accum #(
  parameter int N_TERMS    = 5,
  parameter int PROD_WIDTH = 28,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 10,
  parameter int RELU       = 1
) (
  input  wire logic               ap_clk,
  input  wire logic               ap_rst,
  paramest_nn_mac_accum_if.slave  bus
);
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int RW    = ACC_WIDTH + 1;

  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic signed [RW-1:0] HALF     = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] OUT_MAX  = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN  = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        ov_q, ov_d;
  logic signed [OUT_WIDTH-1:0] res_q, res_d;
  logic                        sat_q, sat_d;

  logic                        w_accept;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] w_bias;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [RW-1:0]        w_rnd;
  logic signed [RW-1:0]        w_r;
  logic signed [OUT_WIDTH-1:0] w_res;
  logic                        w_sat;

  assign w_accept = bus.in_valid & ~ov_q;
  assign w_last   = (cnt_q == LAST_CNT);
  assign w_prod   = {{(ACC_WIDTH-PROD_WIDTH){bus.prod_in[PROD_WIDTH-1]}}, bus.prod_in};
  assign w_bias   = {{(ACC_WIDTH-PROD_WIDTH){bus.bias_in[PROD_WIDTH-1]}}, bus.bias_in};
  assign w_sum    = (cnt_q == '0) ? (w_bias + w_prod) : (acc_q + w_prod);

  // One extra bit of headroom so adding the rounding half can never wrap.
  assign w_rnd = $signed({w_sum[ACC_WIDTH-1], w_sum}) + HALF;
  assign w_r   = w_rnd >>> SHIFT;

  always_comb begin
    w_res = w_r[OUT_WIDTH-1:0];
    w_sat = 1'b0;
    if ((RELU != 0) && (w_r < 0)) begin
      w_res = '0;
    end else if (w_r > OUT_MAX) begin
      w_res = OUT_MAX[OUT_WIDTH-1:0];
      w_sat = 1'b1;
    end else if (w_r < OUT_MIN) begin
      w_res = OUT_MIN[OUT_WIDTH-1:0];
      w_sat = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    ov_d  = ov_q;
    res_d = res_q;
    sat_d = sat_q;
    if (ov_q && bus.out_ready) begin
      ov_d = 1'b0;
    end
    // Terms are only taken while no result is pending, so the two branches never overlap.
    if (w_accept) begin
      acc_d = w_sum;
      if (w_last) begin
        cnt_d = '0;
        ov_d  = 1'b1;
        res_d = w_res;
        sat_d = w_sat;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ov_q  <= ov_d;
      res_q <= res_d;
      sat_q <= sat_d;
    end
  end

  assign bus.in_ready  = ~ov_q;
  assign bus.out_valid = ov_q;
  assign bus.res_out   = res_q;
  assign bus.res_sat   = sat_q;
endmodule

`default_nettype wire

// File: tb/tb_paramest_nn_mac_accum.sv
// Directed bench: ReLU and non-ReLU instances share one stimulus stream.
`default_nettype none

module tb_paramest_nn_mac_accum;
  localparam int PW = 28;
  localparam int OW = 16;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  paramest_nn_mac_accum_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) bus ();
  paramest_nn_mac_accum_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) bus_nr ();

  assign bus_nr.prod_in   = bus.prod_in;
  assign bus_nr.bias_in   = bus.bias_in;
  assign bus_nr.in_valid  = bus.in_valid;
  assign bus_nr.out_ready = bus.out_ready;

  paramest_nn_mac_accum #(.N_TERMS(5), .PROD_WIDTH(PW), .ACC_WIDTH(32), .OUT_WIDTH(OW),
                          .SHIFT(10), .RELU(1)) u_dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  paramest_nn_mac_accum #(.N_TERMS(5), .PROD_WIDTH(PW), .ACC_WIDTH(32), .OUT_WIDTH(OW),
                          .SHIFT(10), .RELU(0)) u_dut_nr (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus_nr)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Five terms of the same value; gap idle cycles after each accepted term.
  task automatic run_group(input longint bias, input longint term, input int gap);
    for (int i = 0; i < 5; i++) begin
      bus.bias_in  = PW'(bias);
      bus.prod_in  = PW'(term);
      bus.in_valid = 1'b1;
      if (i == 4) check("pre_last_ov", bus.out_valid, 0);
      tick();
      bus.in_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic expect_result(input string tag, input longint res, input longint sat,
                               input longint res_nr, input longint sat_nr);
    check({tag, "_ov"}, bus.out_valid, 1);
    check({tag, "_ir"}, bus.in_ready, 0);
    check({tag, "_res"}, bus.res_out, res);
    check({tag, "_sat"}, bus.res_sat, sat);
    check({tag, "_nr_res"}, bus_nr.res_out, res_nr);
    check({tag, "_nr_sat"}, bus_nr.res_sat, sat_nr);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_ov_clr"}, bus.out_valid, 0);
    check({tag, "_ir_set"}, bus.in_ready, 1);
  endtask

  initial begin
    bus.prod_in   = '0;
    bus.bias_in   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_ov", bus.out_valid, 0);
    check("rst_res", bus.res_out, 0);
    check("rst_sat", bus.res_sat, 0);
    ap_rst = 1'b0;
    tick();
    check("rst_ir", bus.in_ready, 1);

    run_group(0, 1024, 0);
    expect_result("basic", 5, 0, 5, 0);
    handshake("basic");

    run_group(512, 0, 0);
    expect_result("round_up", 1, 0, 1, 0);
    handshake("round_up");

    run_group(511, 0, 0);
    expect_result("round_dn", 0, 0, 0, 0);
    handshake("round_dn");

    run_group(0, -2048, 0);
    expect_result("relu", 0, 0, -10, 0);
    handshake("relu");

    run_group(0, 64'sd1 <<< 26, 0);
    expect_result("sat_pos", 32767, 1, 32767, 1);
    handshake("sat_pos");

    run_group(0, -(64'sd1 <<< 26), 0);
    expect_result("sat_neg", 0, 0, -32768, 1);
    handshake("sat_neg");

    run_group(3072, 1024, 1);
    expect_result("gaps", 8, 0, 8, 0);
    handshake("gaps");

    // Result pending while upstream keeps offering terms.
    run_group(0, 1024, 0);
    bus.bias_in  = '0;
    bus.prod_in  = PW'(2048);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ov", bus.out_valid, 1);
      check("hold_ir", bus.in_ready, 0);
      check("hold_res", bus.res_out, 5);
    end
    handshake("hold");
    for (int i = 0; i < 5; i++) tick();
    bus.in_valid = 1'b0;
    expect_result("after_hold", 10, 0, 10, 0);
    handshake("after_hold");

    // Partial group discarded by reset.
    for (int i = 0; i < 3; i++) begin
      bus.bias_in  = '0;
      bus.prod_in  = PW'(1024);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("midrst_ir", bus.in_ready, 1);
    run_group(0, 1024, 0);
    expect_result("midrst", 5, 0, 5, 0);
    handshake("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
